// File: rtl/hzd_ctrl.sv
// rtl/hzd_ctrl.sv - pipeline hazard controller for the 5-stage core
// Turns load-use, dmem wait, mult/div and taken branches into per-stage stall/flush/bubble controls.
module hzd_ctrl #(
  parameter int MUL_CYC = 4,
  parameter int DIV_CYC = 32,
  parameter int CNT_W   = 6,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hzdlu,
  input  logic              EX_branch_taken,
  input  logic              EX_mdu_start,
  input  logic              EX_mdu_isdiv,
  input  logic              MEM_dmem_wait,
  output logic              IF_stall,
  output logic              ID_stall,
  output logic              EX_stall,
  output logic              MEM_stall,
  output logic              ID_flush,
  output logic              EX_flush,
  output logic              MEM_bubble,
  output logic              WB_bubble,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [PERF_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_LU  = 2'd1,
    ST_MDU = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] L_MUL_LOAD = CNT_W'(MUL_CYC - 2);
  localparam logic [CNT_W-1:0] L_DIV_LOAD = CNT_W'(DIV_CYC - 2);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [PERF_W-1:0] r_stall_cnt;

  logic w_if_stall, w_id_stall, w_ex_stall, w_mem_stall;
  logic w_id_flush, w_ex_flush, w_mem_bubble, w_wb_bubble;
  logic w_mdu_busy, w_mdu_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_if_stall && (r_stall_cnt != {PERF_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_if_stall   = 1'b0;
    w_id_stall   = 1'b0;
    w_ex_stall   = 1'b0;
    w_mem_stall  = 1'b0;
    w_id_flush   = 1'b0;
    w_ex_flush   = 1'b0;
    w_mem_bubble = 1'b0;
    w_wb_bubble  = 1'b0;
    w_mdu_busy   = 1'b0;
    w_mdu_done   = 1'b0;
    case (r_state)
      ST_RUN, ST_LU: begin
        // LU differs from RUN only in ignoring hzdlu: the load has reached WB.
        if (MEM_dmem_wait) begin
          w_if_stall  = 1'b1;
          w_id_stall  = 1'b1;
          w_ex_stall  = 1'b1;
          w_mem_stall = 1'b1;
          w_wb_bubble = 1'b1;
          w_state_nxt = ST_RUN;
        end else if ((r_state == ST_RUN) && hzdlu) begin
          w_if_stall   = 1'b1;
          w_id_stall   = 1'b1;
          w_ex_stall   = 1'b1;
          w_mem_bubble = 1'b1;
          w_state_nxt  = ST_LU;
        end else if (EX_mdu_start) begin
          w_if_stall   = 1'b1;
          w_id_stall   = 1'b1;
          w_ex_stall   = 1'b1;
          w_mem_bubble = 1'b1;
          w_mdu_busy   = 1'b1;
          w_cnt_nxt    = EX_mdu_isdiv ? L_DIV_LOAD : L_MUL_LOAD;
          w_state_nxt  = ST_MDU;
        end else if (EX_branch_taken) begin
          w_id_flush  = 1'b1;
          w_ex_flush  = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_MDU: begin
        w_mdu_busy = 1'b1;
        if (r_cnt != '0) begin
          w_if_stall   = 1'b1;
          w_id_stall   = 1'b1;
          w_ex_stall   = 1'b1;
          w_mem_bubble = 1'b1;
          w_cnt_nxt    = r_cnt - 1'b1;
        end else begin
          w_mdu_done  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Gating by rst_n makes every control drop the instant reset asserts.
  assign IF_stall   = rst_n & w_if_stall;
  assign ID_stall   = rst_n & w_id_stall;
  assign EX_stall   = rst_n & w_ex_stall;
  assign MEM_stall  = rst_n & w_mem_stall;
  assign ID_flush   = rst_n & w_id_flush;
  assign EX_flush   = rst_n & w_ex_flush;
  assign MEM_bubble = rst_n & w_mem_bubble;
  assign WB_bubble  = rst_n & w_wb_bubble;
  assign mdu_busy   = rst_n & w_mdu_busy;
  assign mdu_done   = rst_n & w_mdu_done;
  assign stall_cnt  = r_stall_cnt & {PERF_W{rst_n}};

endmodule
